// File: rtl/stdp_array_learner_pkg.sv
// Shared FSM type and saturating weight arithmetic for stdp_array_learner.
// The LTD state only exists when STDP_LTD_EN is defined.
package stdp_pkg;

`ifdef STDP_LTD_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LTP,
        ST_LTD
    } stdp_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_LTP
    } stdp_state_e;
`endif

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Delta is WIN - dt, so a coincident spike gives the largest step.
    function automatic int ltp_delta(
        input int w,
        input int dt,
        input int win,
        input int w_w
    );
        int s;
        int w_max;
        w_max = (1 << w_w) - 1;
        s = w + (win - dt);
        return (s > w_max) ? w_max : s;
    endfunction

    function automatic int ltd_delta(
        input int w,
        input int dt,
        input int win
    );
        int s;
        s = w - (win - dt);
        return (s < 0) ? 0 : s;
    endfunction

endpackage

// File: rtl/stdp_array_learner_if.sv
// Spike, control and weight-read bundle between the neuron core and
// the STDP learner.
interface stdp_array_learner_if
    import stdp_pkg::*;
#(
    parameter int N_PRE = 16,
    parameter int W_W   = 4
);
    localparam int AW = idx_w(N_PRE);

    logic             write;
    logic             post_spike;
    logic [N_PRE-1:0] pre_spike;
    logic [AW-1:0]    rd_addr;
    logic [W_W-1:0]   rd_data;
    logic             busy;
    logic             done;
    logic             missed;

    modport master (
        output write,
        output post_spike,
        output pre_spike,
        output rd_addr,
        input  rd_data,
        input  busy,
        input  done,
        input  missed
    );

    modport slave (
        input  write,
        input  post_spike,
        input  pre_spike,
        input  rd_addr,
        output rd_data,
        output busy,
        output done,
        output missed
    );

endinterface

// File: rtl/stdp_array_learner_spike_history.sv
// One channel's spike history: WIN-1 stored samples plus the live input,
// and a priority encoder returning the most recent hit within the window.
module spike_history
    import stdp_pkg::*;
#(
    parameter int WIN = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pre,
    output logic                      hit,
    output logic [idx_w(WIN)-1:0]     dt
);
    localparam int DW = idx_w(WIN);

    logic [WIN-2:0] sh_q;
    logic [WIN-2:0] sh_d;
    logic [WIN-1:0] win;

    // win[k] = spike sampled k edges ago; bit 0 is this edge's sample.
    assign win = {sh_q, pre};

    always_comb begin
        sh_d = win[WIN-2:0];
        hit  = 1'b0;
        dt   = '0;
        for (int k = WIN - 1; k >= 0; k--) begin
            if (win[k]) begin
                hit = 1'b1;
                dt  = DW'(k);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/stdp_array_learner.sv
// STDP weight engine: one LTP scan per accepted post spike, plus an LTD
// window and second scan when STDP_LTD_EN is defined.
module stdp_array_learner
    import stdp_pkg::*;
#(
    parameter int N_PRE  = 16,
    parameter int WIN    = 4,
    parameter int W_W    = 4,
    parameter int W_INIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    stdp_array_learner_if.slave  bus
);
    localparam int AW = idx_w(N_PRE);
    localparam int DW = idx_w(WIN);
    localparam logic [AW-1:0] LAST = AW'(N_PRE - 1);

    stdp_state_e      state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [W_W-1:0]   w_q [N_PRE];
    logic [W_W-1:0]   w_d [N_PRE];
    logic [N_PRE-1:0] hit_now;
    logic [DW-1:0]    dt_now [N_PRE];
    logic [N_PRE-1:0] ltp_hit_q, ltp_hit_d;
    logic [DW-1:0]    ltp_dt_q [N_PRE];
    logic [DW-1:0]    ltp_dt_d [N_PRE];
    logic [W_W-1:0]   rd_q, rd_d;
    logic             done_q, done_d;
    logic             missed_q, missed_d;
    logic             busy;
    logic             accept;
    logic             last;

`ifdef STDP_LTD_EN
    logic [N_PRE-1:0] ltd_hit_q, ltd_hit_d;
    logic [DW-1:0]    ltd_dt_q [N_PRE];
    logic [DW-1:0]    ltd_dt_d [N_PRE];
    logic [DW-1:0]    win_q, win_d;
`endif

    for (genvar g = 0; g < N_PRE; g++) begin : g_hist
        spike_history #(
            .WIN (WIN)
        ) u_hist (
            .clock (clock),
            .reset (reset),
            .pre   (bus.pre_spike[g]),
            .hit   (hit_now[g]),
            .dt    (dt_now[g])
        );
    end

    assign busy   = (state_q != ST_IDLE);
    assign accept = bus.post_spike && bus.write && !busy;
    assign last   = (idx_q == LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_d       = w_q;
        ltp_hit_d = ltp_hit_q;
        ltp_dt_d  = ltp_dt_q;
        rd_d      = w_q[bus.rd_addr];
        done_d    = 1'b0;
        missed_d  = missed_q | (bus.post_spike && busy);
`ifdef STDP_LTD_EN
        ltd_hit_d = ltd_hit_q;
        ltd_dt_d  = ltd_dt_q;
        win_d     = win_q;
        // First pre spike per channel within the open window wins.
        if (win_q != '0) begin
            for (int i = 0; i < N_PRE; i++) begin
                if (bus.pre_spike[i] && !ltd_hit_q[i]) begin
                    ltd_hit_d[i] = 1'b1;
                    ltd_dt_d[i]  = win_q;
                end
            end
            win_d = (win_q == DW'(WIN - 1)) ? '0 : win_q + DW'(1);
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_LTP;
                    idx_d     = '0;
                    ltp_hit_d = hit_now;
                    ltp_dt_d  = dt_now;
`ifdef STDP_LTD_EN
                    ltd_hit_d = '0;
                    win_d     = DW'(1);
`endif
                end
            end
            ST_LTP: begin
                if (ltp_hit_q[idx_q]) begin
                    w_d[idx_q] = W_W'(ltp_delta(int'(w_q[idx_q]),
                        int'(ltp_dt_q[idx_q]), WIN, W_W));
                end
                idx_d = last ? '0 : idx_q + AW'(1);
                if (last) begin
`ifdef STDP_LTD_EN
                    state_d = ST_LTD;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef STDP_LTD_EN
            ST_LTD: begin
                if (ltd_hit_q[idx_q]) begin
                    w_d[idx_q] = W_W'(ltd_delta(int'(w_q[idx_q]),
                        int'(ltd_dt_q[idx_q]), WIN));
                end
                idx_d = last ? '0 : idx_q + AW'(1);
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ltp_hit_q <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            missed_q  <= 1'b0;
            for (int i = 0; i < N_PRE; i++) begin
                w_q[i]      <= W_W'(W_INIT);
                ltp_dt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            w_q       <= w_d;
            ltp_hit_q <= ltp_hit_d;
            ltp_dt_q  <= ltp_dt_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            missed_q  <= missed_d;
        end
    end

`ifdef STDP_LTD_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ltd_hit_q <= '0;
            win_q     <= '0;
            for (int i = 0; i < N_PRE; i++) begin
                ltd_dt_q[i] <= '0;
            end
        end else begin
            ltd_hit_q <= ltd_hit_d;
            ltd_dt_q  <= ltd_dt_d;
            win_q     <= win_d;
        end
    end
`endif

    assign bus.rd_data = rd_q;
    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.missed  = missed_q;

endmodule

// File: tb/tb_stdp_array_learner.sv
// Bench for stdp_array_learner: directed table, corner sequences and a
// random run against an event-log reference model.
module tb_stdp_array_learner;

    localparam int N      = 16;
    localparam int WIN    = 4;
    localparam int W_W    = 4;
    localparam int W_INIT = 8;
    localparam int W_MAX  = 15;
    localparam int MAXE   = 8192;
`ifdef STDP_LTD_EN
    localparam bit LTD = 1'b1;
`else
    localparam bit LTD = 1'b0;
`endif
    localparam int LAT = LTD ? 2 * N : N;

    typedef struct {
        int ch;
        int k;
        int nb;
        int exp_w;
    } ltp_vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    stdp_array_learner_if #(.N_PRE(N), .W_W(W_W)) bus();

    stdp_array_learner #(
        .N_PRE  (N),
        .WIN    (WIN),
        .W_W    (W_W),
        .W_INIT (W_INIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int rst_e  = 0;
    int acc_t  = -1000;
    int fin_e  = -1000;
    int m_w [N];
    bit m_missed;
    bit exp_busy;
    bit exp_done;
    logic [N-1:0] pre_log [MAXE];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit pre_at(input int e, input int ch);
        if (e <= rst_e || e > cyc) return 1'b0;
        return pre_log[e][ch];
    endfunction

    // Model: every sampled edge is logged; learning reads the log.
    task automatic model_edge(input bit p, input bit w);
        bit busy_at;
        int dt;
        busy_at = (cyc > acc_t) && (cyc <= fin_e);
        if (p && busy_at) begin
            m_missed = 1'b1;
        end else if (p && w) begin
            acc_t = cyc;
            fin_e = cyc + LAT;
            for (int ch = 0; ch < N; ch++) begin
                dt = -1;
                for (int k = 0; k < WIN && dt < 0; k++)
                    if (pre_at(cyc - k, ch)) dt = k;
                if (dt >= 0) begin
                    m_w[ch] = m_w[ch] + (WIN - dt);
                    if (m_w[ch] > W_MAX) m_w[ch] = W_MAX;
                end
            end
        end
        if (LTD && cyc == fin_e) begin
            for (int ch = 0; ch < N; ch++) begin
                dt = -1;
                for (int k = 1; k < WIN && dt < 0; k++)
                    if (pre_at(acc_t + k, ch)) dt = k;
                if (dt >= 0) begin
                    m_w[ch] = m_w[ch] - (WIN - dt);
                    if (m_w[ch] < 0) m_w[ch] = 0;
                end
            end
        end
        exp_done = (cyc == fin_e);
        exp_busy = (cyc >= acc_t) && (cyc < fin_e);
    endtask

    task automatic step(input bit p, input bit w, input logic [N-1:0] pr);
        bus.post_spike = p;
        bus.write      = w;
        bus.pre_spike  = pr;
        @(posedge clock);
        cyc++;
        if (cyc >= MAXE) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d",
                     cyc, MAXE);
            $fatal(1);
        end
        pre_log[cyc] = pr;
        model_edge(p, w);
        #1;
        chk("busy", int'(bus.busy), int'(exp_busy));
        chk("done", int'(bus.done), int'(exp_done));
        chk("missed", int'(bus.missed), int'(m_missed));
    endtask

    task automatic do_reset();
        bus.post_spike = 1'b0;
        bus.write      = 1'b0;
        bus.pre_spike  = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_missed", int'(bus.missed), 0);
        chk("rst_rdata", int'(bus.rd_data), 0);
        @(posedge clock);
        cyc++;
        pre_log[cyc] = '0;
        #1;
        reset    = 1'b0;
        rst_e    = cyc;
        acc_t    = -1000;
        fin_e    = -1000;
        m_missed = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = W_INIT;
    endtask

    task automatic rd_check(input int a, input int exp, input string nm);
        bus.rd_addr = 4'(a);
        step(1'b0, 1'b0, '0);
        chk(nm, int'(bus.rd_data), exp);
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int n = 0; n < 2 * LAT + 8 && !seen; n++) begin
            step(1'b0, 1'b0, '0);
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - acc_t;
            end
        end
        chk("done_seen", int'(seen), 1);
    endtask

    initial begin
        ltp_vec_t tv [5];
        int lat;
        int nd;
        int ltd_exp [4];
        bit p;
        bit w;
        logic [N-1:0] pr;

        tv[0] = '{ch: 3,  k: 2, nb: 4,  exp_w: 10};
        tv[1] = '{ch: 0,  k: 0, nb: 1,  exp_w: 12};
        tv[2] = '{ch: 7,  k: 3, nb: 8,  exp_w: 9};
        tv[3] = '{ch: 9,  k: 4, nb: 10, exp_w: 8};
        tv[4] = '{ch: 15, k: 1, nb: 14, exp_w: 11};
        ltd_exp = '{5, 2, 0, 0};

        bus.rd_addr = '0;
        do_reset();
        for (int i = 0; i < N; i++) rd_check(i, W_INIT, "rst_weight");

        for (int i = 0; i < 5; i++) begin
            do_reset();
            pr = N'(1) << tv[i].ch;
            if (tv[i].k == 0) begin
                step(1'b1, 1'b1, pr);
            end else begin
                step(1'b0, 1'b0, pr);
                for (int j = 1; j < tv[i].k; j++) step(1'b0, 1'b0, '0);
                step(1'b1, 1'b1, '0);
            end
            chk("ltp_accept_busy", int'(bus.busy), 1);
            wait_done(lat);
            chk("ltp_latency", lat, LAT);
            rd_check(tv[i].ch, tv[i].exp_w, "ltp_weight");
            rd_check(tv[i].nb, W_INIT, "ltp_neighbour");
        end

        do_reset();
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b0, N'(1));
            step(1'b1, 1'b1, '0);
            wait_done(lat);
        end
        rd_check(0, 14, "sat_preload");
        step(1'b1, 1'b1, N'(1));
        wait_done(lat);
        rd_check(0, W_MAX, "sat_weight");

`ifdef STDP_LTD_EN
        do_reset();
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 1'b1, '0);
            step(1'b0, 1'b0, N'(1) << 5);
            wait_done(lat);
            chk("ltd_latency", lat, LAT);
            rd_check(5, ltd_exp[r], "ltd_weight");
        end
`endif

        do_reset();
        step(1'b1, 1'b1, N'(1) << 2);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, '0);
        chk("overrun_missed", int'(bus.missed), 1);
        wait_done(lat);
        chk("overrun_latency", lat, LAT);
        rd_check(2, 12, "overrun_weight");
        nd = 0;
        for (int j = 0; j < LAT + 8; j++) begin
            step(1'b0, 1'b0, '0);
            if (bus.done) nd++;
        end
        chk("overrun_single", nd, 0);

        step(1'b1, 1'b0, N'(1) << 4);
        chk("gate_busy", int'(bus.busy), 0);
        step(1'b0, 1'b0, '0);
        chk("gate_busy_hold", int'(bus.busy), 0);
        rd_check(4, W_INIT, "gate_weight");

        do_reset();
        step(1'b1, 1'b1, N'(1) << 6);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, '0);
        do_reset();
        for (int i = 0; i < N; i++) rd_check(i, W_INIT, "midrst_weight");
        step(1'b1, 1'b1, N'(1) << 6);
        chk("midrst_accept", int'(bus.busy), 1);
        wait_done(lat);
        chk("midrst_latency", lat, LAT);
        rd_check(6, 12, "midrst_weight6");

        do_reset();
        for (int r = 0; r < 6; r++) begin
            if (r == 3) do_reset();
            for (int j = 0; j < 300; j++) begin
                p  = ($urandom_range(0, 5) == 0);
                w  = ($urandom_range(0, 3) != 0);
                pr = N'($urandom & $urandom & $urandom);
                step(p, w, pr);
            end
            for (int j = 0; j < LAT + 4; j++) step(1'b0, 1'b0, '0);
            for (int i = 0; i < N; i++) rd_check(i, m_w[i], "rand_weight");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/stdp_array_learner.md
# stdp_array_learner

Parametrised spike-timing-dependent plasticity engine for one postsynaptic neuron and `N_PRE` presynaptic channels. It keeps a per-channel spike history and an on-chip weight array. On each accepted postsynaptic spike it scans every channel once and applies a saturating potentiation (LTP) step. Optionally, a second scan applies depression (LTD). It sits between the spike-input shift registers and the neuron core, which reads weights through a registered port.

## Interface
- `N_PRE`, 16: presynaptic channel count; must be ≥ `WIN`.
- `WIN`, 4: timing window in cycles; history depth.
- `W_W`, 4: weight width.
- `W_INIT`, 8: reset value of every weight.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `write` input 1: learning enable, sampled only on the accepted post-spike edge.
- `post_spike` input 1: postsynaptic spike, one sample per cycle.
- `pre_spike` input `N_PRE`: presynaptic spikes; bit i is channel i.
- `rd_addr` input clog2(`N_PRE`): weight read address.
- `rd_data` output `W_W`: registered weight read.
- `busy` output 1: a scan or LTD window is in progress.
- `done` output 1: one-cycle pulse on the last update edge.
- `missed` output 1: sticky; a post spike arrived while `busy`.

## Operation
- History: `hist[i][k]` = channel i spiked k edges ago, for k = 0..WIN-1. It shifts every cycle, including while busy.
- Accept: when `post_spike`=1, `busy`=0 and `write`=1:
  - snapshot `dt_ltp[i]` = smallest k with `hist[i][k]`=1, including this edge's sample as k=0;
  - clear the LTD record;
  - enter LTP.
- `post_spike` while `write`=0 is ignored.
- `post_spike` while `busy`=1 is ignored and sets `missed`.
- LTP update: channel i gets `w = min(w + (WIN - dt), 2^W_W - 1)`. No hit means no change.
- LTD window: pre spikes on edges t+1..t+WIN-1 record `dt_ltd[i]` = the first offset k (1..WIN-1). Later spikes are ignored.
- LTD update: channel i gets `w = max(w - (WIN - dt), 0)`. No record means no change.
- Arithmetic uses a `W_W+1`-bit intermediate. Delta is 1..WIN.
- FSM states: IDLE, LTP, LTD.
  - IDLE→LTP on accept.
  - LTP→LTD after channel N_PRE-1 (LTD build), or LTP→IDLE.
  - LTD→IDLE after channel N_PRE-1.
- Scan index counts 0..N_PRE-1, one channel per cycle, then wraps to 0.
- Read of a channel on the same edge it is written returns the old value.

## Timing
- Post spike accepted at edge t.
- `busy` is high from after edge t until after the final update edge.
- LTP writes channel i at edge t+1+i.
- LTD writes channel i at edge t+N_PRE+1+i. The window closes before the LTD scan starts because `N_PRE` ≥ `WIN`.
- `done` pulses on the final edge:
  - t+2·N_PRE with LTD;
  - t+N_PRE without LTD.
- `busy` falls on the same final edge as `done`. A new post spike is accepted from the next edge.
- `rd_data` latency is 1 cycle.
- Reset at any time, including mid-scan, is asynchronous:
  - weights return to `W_INIT`;
  - history, snapshots, FSM (IDLE), `busy`, `done` and `missed` are cleared;
  - `rd_data` returns to 0.

## Configuration
- `STDP_LTD_EN` defined: LTD window, record and LTD scan are built; the update cycle is 2·N_PRE.
- `STDP_LTD_EN` undefined: LTP only; the LTD state and records are absent; the update cycle is N_PRE.

## Structure
- Package `stdp_pkg` holds:
  - the FSM state enum;
  - the `ltp_delta`/`ltd_delta` saturating functions;
  - the index-width constant helper.
- Sub-module `spike_history`: per-channel WIN-deep shift register plus first-hit priority encoder, which returns hit and dt. It is instantiated `N_PRE` times.

## Test plan
- Reset: all outputs 0; reading every address returns 8.
- LTP: pre ch3 two edges before post, `write`=1 → ch3 = 10, others stay 8; `done` pulses at t+32 (LTD) or t+16.
- Saturation: ch0 preloaded to 14, pre and post on the same edge → ch0 = 15, not 18 or a wrapped value.
- LTD (macro defined): pre ch5 one edge after post → ch5 = 5. Four repeats leave ch5 = 0 (floor).
- Overrun and gating: post at t and t+3 → one update only, `missed`=1. Post with `write`=0 → no change, `busy` stays 0.
- Reset mid-LTP at t+5 → all weights 8, `busy`=0. A post spike afterwards is accepted normally.
